// File: rtl/ika87ad_membus_pkg.sv
// Shared types and helpers for the IKA87AD memory-bus arbiter.
package ika87ad_membus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCpuRd,
        StCpuRdLat,
        StCpuWr,
        StHostRd,
        StHostRdLat,
        StHostWr
    } state_e;

    localparam logic [7:0] OpenBusDefault = 8'hFF;

    // True when a CPU address falls inside the 2^aw byte window starting at base.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                       input int unsigned aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/ika87ad_membus_edge.sv
// Registers one active-low CPU strobe and flags its falling edge.
module ika87ad_membus_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_n_i,
    output logic strobe_q_o,
    output logic fall_o
);

    logic strobe_q;

    // Strobe history register; idles high so reset never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= strobe_n_i;
        end
    end

    assign strobe_q_o = strobe_q;
    // Edge is qualified by the registered previous level and the level being sampled now.
    assign fall_o     = strobe_q & ~strobe_n_i;

endmodule

// File: rtl/ika87ad_membus_arb.sv
// Arbitrates one synchronous single-port RAM between the IKA87AD CPU bus and a host port.
// CPU accesses always win; a CPU edge seen during a host access is parked and served next.
module ika87ad_membus_arb
    import ika87ad_membus_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter logic [15:0] BASE     = 16'h0000,
    parameter logic [7:0]  OPEN_BUS = OpenBusDefault
) (
    input  logic          i_EMUCLK,
    input  logic          i_RESET,
    input  logic [15:0]   i_CPU_A,
    input  logic          i_CPU_RD_n,
    input  logic          i_CPU_WR_n,
    input  logic [7:0]    i_CPU_DO,
    output logic [7:0]    o_CPU_DI,
    input  logic          i_HOST_REQ,
    input  logic          i_HOST_WE,
    input  logic [AW-1:0] i_HOST_A,
    input  logic [7:0]    i_HOST_D,
    output logic          o_HOST_ACK,
    output logic [7:0]    o_HOST_Q,
    output logic [AW-1:0] o_RAM_A,
    output logic          o_RAM_WE,
    output logic [7:0]    o_RAM_D,
    input  logic [7:0]    i_RAM_Q
);

    logic rd_q, wr_q, rd_fall, wr_fall;

    ika87ad_membus_edge u_rd_edge (
        .clk_i      (i_EMUCLK),
        .rst_i      (i_RESET),
        .strobe_n_i (i_CPU_RD_n),
        .strobe_q_o (rd_q),
        .fall_o     (rd_fall)
    );

    ika87ad_membus_edge u_wr_edge (
        .clk_i      (i_EMUCLK),
        .rst_i      (i_RESET),
        .strobe_n_i (i_CPU_WR_n),
        .strobe_q_o (wr_q),
        .fall_o     (wr_fall)
    );

    state_e        state_q;
    logic          pend_q, pend_wr_q;
    logic [15:0]   pend_a_q;
    logic [7:0]    cpu_di_q, host_q_q, ram_d_q;
    logic          host_ack_q, ram_we_q;
    logic [AW-1:0] ram_a_q;

    logic          live_wr, live_rd, live_any;
    logic          start_any, start_wr, start_hit, host_ok;
    logic [15:0]   start_a;

    // A read edge while WR_n is low is dropped: simultaneous strobes mean write.
    assign live_wr  = wr_fall;
    assign live_rd  = rd_fall & i_CPU_WR_n;
    assign live_any = live_wr | live_rd;

    // Select the CPU cycle to start: a parked edge first, otherwise a fresh one.
    always_comb begin
        start_any = pend_q | live_any;
        start_wr  = pend_q ? pend_wr_q : live_wr;
        start_a   = pend_q ? pend_a_q : i_CPU_A;
        start_hit = in_window(start_a, BASE, AW);
        host_ok   = i_HOST_REQ & rd_q & wr_q & ~host_ack_q;
    end

    // Arbiter FSM with registered RAM, CPU and host outputs.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RESET) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pend_wr_q  <= 1'b0;
            pend_a_q   <= '0;
            cpu_di_q   <= OPEN_BUS;
            host_q_q   <= '0;
            host_ack_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
        end else begin
            host_ack_q <= 1'b0;
            ram_we_q   <= 1'b0;
            if (state_q != StIdle && live_any) begin
                pend_q    <= 1'b1;
                pend_wr_q <= live_wr;
                pend_a_q  <= i_CPU_A;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_any) begin
                        // Consuming a parked edge; re-park a fresh one arriving this cycle.
                        if (pend_q) begin
                            pend_q    <= live_any;
                            pend_wr_q <= live_wr;
                            pend_a_q  <= i_CPU_A;
                        end
                        if (start_hit) begin
                            ram_a_q <= start_a[AW-1:0];
                            if (start_wr) begin
                                ram_we_q <= 1'b1;
                                ram_d_q  <= i_CPU_DO;
                                state_q  <= StCpuWr;
                            end else begin
                                state_q  <= StCpuRd;
                            end
                        end else if (!start_wr) begin
                            cpu_di_q <= OPEN_BUS;
                        end
                    end else if (host_ok) begin
                        ram_a_q <= i_HOST_A;
                        if (i_HOST_WE) begin
                            ram_we_q   <= 1'b1;
                            ram_d_q    <= i_HOST_D;
                            host_ack_q <= 1'b1;
                            state_q    <= StHostWr;
                        end else begin
                            state_q    <= StHostRd;
                        end
                    end
                end
                StCpuRd:     state_q <= StCpuRdLat;
                StCpuRdLat: begin
                    cpu_di_q <= i_RAM_Q;
                    state_q  <= StIdle;
                end
                StCpuWr:     state_q <= StIdle;
                StHostRd:    state_q <= StHostRdLat;
                StHostRdLat: begin
                    host_q_q   <= i_RAM_Q;
                    host_ack_q <= 1'b1;
                    state_q    <= StIdle;
                end
                StHostWr:    state_q <= StIdle;
                default:     state_q <= StIdle;
            endcase
        end
    end

    assign o_CPU_DI   = cpu_di_q;
    assign o_HOST_ACK = host_ack_q;
    assign o_HOST_Q   = host_q_q;
    assign o_RAM_A    = ram_a_q;
    assign o_RAM_WE   = ram_we_q;
    assign o_RAM_D    = ram_d_q;

endmodule

// File: tb/tb_ika87ad_membus_arb.sv
// Self-checking bench for ika87ad_membus_arb with a behavioural RAM and reference memory.
module tb_ika87ad_membus_arb;

    localparam int unsigned AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_a;
    logic        cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_do, cpu_di;
    logic        host_req, host_we, host_ack;
    logic [11:0] host_a, ram_a;
    logic [7:0]  host_d, host_q, ram_d, ram_q;
    logic        ram_we;

    always #5 clk = ~clk;

    ika87ad_membus_arb #(
        .AW       (AW),
        .BASE     (16'h0000),
        .OPEN_BUS (8'hFF)
    ) dut (
        .i_EMUCLK   (clk),
        .i_RESET    (rst),
        .i_CPU_A    (cpu_a),
        .i_CPU_RD_n (cpu_rd_n),
        .i_CPU_WR_n (cpu_wr_n),
        .i_CPU_DO   (cpu_do),
        .o_CPU_DI   (cpu_di),
        .i_HOST_REQ (host_req),
        .i_HOST_WE  (host_we),
        .i_HOST_A   (host_a),
        .i_HOST_D   (host_d),
        .o_HOST_ACK (host_ack),
        .o_HOST_Q   (host_q),
        .o_RAM_A    (ram_a),
        .o_RAM_WE   (ram_we),
        .o_RAM_D    (ram_d),
        .i_RAM_Q    (ram_q)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    // Reference memory: updated only from the bench's own view of which accesses hit.
    logic [7:0] ref_mem [0:4095];
    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int ack_cnt = 0;
    logic [11:0] last_we_a = '0;
    logic [7:0]  last_we_d = '0;

    // Bus activity counters, sampled on the active edge before outputs update.
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt    <= we_cnt + 1;
            last_we_a <= ram_a;
            last_we_d <= ram_d;
        end
        if (host_ack) ack_cnt <= ack_cnt + 1;
    end

    function automatic logic hit(input logic [15:0] a);
        return a < 16'h1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_a = a; cpu_do = d; cpu_wr_n = 1'b0;
        tick(); tick();
        cpu_wr_n = 1'b1;
        tick(); tick();
        if (hit(a)) ref_mem[a[11:0]] = d;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_a = a; cpu_rd_n = 1'b0;
        tick(); tick(); tick();
        d = cpu_di;
        cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic host_access(input logic we, input logic [11:0] a, input logic [7:0] d,
                               output logic [7:0] q, output int lat, output logic width_ok);
        host_req = 1'b1; host_we = we; host_a = a; host_d = d; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (host_ack) begin lat = k; break; end
        end
        q = host_q;
        host_req = 1'b0;
        tick();
        width_ok = !host_ack;
        if (we && lat > 0) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL reset_cpu_di got %h want ff", cpu_di); end
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", host_ack); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", ram_we); end
        checks++; if (ram_a !== 12'h000) begin failures++; $display("FAIL reset_ram_a got %h want 000", ram_a); end
        checks++; if (ram_d !== 8'h00) begin failures++; $display("FAIL reset_ram_d got %h want 00", ram_d); end
        checks++; if (host_q !== 8'h00) begin failures++; $display("FAIL reset_host_q got %h want 00", host_q); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write_read();
        int w0;
        logic [7:0] d;
        w0 = we_cnt;
        cpu_write(16'h0010, 8'h5A);
        checks++; if (we_cnt - w0 != 1) begin failures++; $display("FAIL wr_pulses got %0d want 1", we_cnt - w0); end
        checks++; if (last_we_a !== 12'h010) begin failures++; $display("FAIL wr_addr got %h want 010", last_we_a); end
        checks++; if (last_we_d !== 8'h5A) begin failures++; $display("FAIL wr_data got %h want 5a", last_we_d); end
        cpu_read(16'h0010, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rd_edge3 got %h want 5a", d); end
    endtask

    task automatic test_read_miss();
        int w0;
        logic [11:0] a0;
        logic [7:0] d;
        w0 = we_cnt; a0 = ram_a;
        cpu_a = 16'hFFF0; cpu_rd_n = 1'b0;
        tick();
        checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL miss_openbus got %h want ff", cpu_di); end
        tick(); tick();
        cpu_rd_n = 1'b1;
        tick();
        checks++; if (we_cnt != w0) begin failures++; $display("FAIL miss_no_we got %0d want %0d", we_cnt, w0); end
        checks++; if (ram_a !== a0) begin failures++; $display("FAIL miss_ram_a got %h want %h", ram_a, a0); end
        cpu_write(16'h2010, 8'h11);
        checks++; if (we_cnt != w0) begin failures++; $display("FAIL wmiss_no_we got %0d want %0d", we_cnt, w0); end
        cpu_read(16'h0010, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL wmiss_kept got %h want 5a", d); end
    endtask

    task automatic test_host_write_read();
        logic [7:0] q, d;
        int lat;
        logic wok;
        host_access(1'b1, 12'h0FF, 8'hC3, q, lat, wok);
        checks++; if (lat < 1) begin failures++; $display("FAIL hwr_ack got none want ack"); end
        checks++; if (wok !== 1'b1) begin failures++; $display("FAIL hwr_ack_width got long want 1 cycle"); end
        checks++; if (host_q !== 8'h00) begin failures++; $display("FAIL hwr_q_held got %h want 00", host_q); end
        host_access(1'b0, 12'h0FF, 8'h00, q, lat, wok);
        checks++; if (lat < 1) begin failures++; $display("FAIL hrd_ack got none want ack"); end
        checks++; if (wok !== 1'b1) begin failures++; $display("FAIL hrd_ack_width got long want 1 cycle"); end
        checks++; if (q !== 8'hC3) begin failures++; $display("FAIL hrd_q got %h want c3", q); end
        cpu_read(16'h00FF, d);
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL hwr_cpu_view got %h want c3", d); end
    endtask

    task automatic test_host_then_cpu();
        logic [7:0] q, d, hq;
        int lat, ack_k, data_k;
        logic wok;
        cpu_write(16'h0123, 8'h7E);
        host_access(1'b1, 12'h456, 8'hA1, q, lat, wok);
        cpu_read(16'hFFF0, d);
        host_req = 1'b1; host_we = 1'b0; host_a = 12'h456;
        tick();
        cpu_a = 16'h0123; cpu_rd_n = 1'b0;
        ack_k = -1; data_k = -1; hq = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (host_ack && ack_k < 0) begin ack_k = k; hq = host_q; host_req = 1'b0; end
            if (cpu_di === 8'h7E && data_k < 0) data_k = k;
        end
        cpu_rd_n = 1'b1;
        tick();
        checks++; if (!(data_k > 0 && data_k <= 5)) begin failures++; $display("FAIL prio_cpu_lat got %0d want <=5", data_k); end
        checks++; if (!(ack_k > 0 && ack_k < data_k)) begin failures++; $display("FAIL prio_host_first got ack %0d data %0d", ack_k, data_k); end
        checks++; if (hq !== 8'hA1) begin failures++; $display("FAIL prio_host_q got %h want a1", hq); end
    endtask

    task automatic test_back_to_back();
        int st [6];
        int issued, head, acks, hq_bad, max_lat, lat;
        for (int i = 0; i < 6; i++) cpu_write(16'h0200 + 16'(i), 8'h40 + 8'(i));
        host_req = 1'b1; host_we = 1'b0; host_a = 12'h456;
        issued = 0; head = 0; acks = 0; hq_bad = 0; max_lat = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 0 && issued < 6) begin
                cpu_a = 16'h0200 + 16'(issued); cpu_rd_n = 1'b0; st[issued] = c; issued++;
            end
            if (c % 4 == 2) cpu_rd_n = 1'b1;
            tick();
            if (host_ack) begin
                acks++;
                if (host_q !== ref_mem[12'h456]) hq_bad++;
            end
            if (head < issued) begin
                lat = c + 1 - st[head];
                if (cpu_di === 8'h40 + 8'(head)) begin
                    if (lat > max_lat) max_lat = lat;
                    head++;
                end else if (lat > 5 && lat > max_lat) begin
                    max_lat = lat;
                end
            end
        end
        host_req = 1'b0; cpu_rd_n = 1'b1;
        tick(); tick();
        checks++; if (head != 6) begin failures++; $display("FAIL b2b_done got %0d want 6", head); end
        checks++; if (max_lat > 5) begin failures++; $display("FAIL b2b_lat got %0d want <=5", max_lat); end
        checks++; if (acks < 1) begin failures++; $display("FAIL b2b_host_ack got %0d want >=1", acks); end
        checks++; if (hq_bad != 0) begin failures++; $display("FAIL b2b_host_q got %0d bad want 0", hq_bad); end
    endtask

    task automatic test_both_strobes();
        int w0;
        logic [7:0] d;
        cpu_read(16'hFFF0, d);
        w0 = we_cnt;
        cpu_a = 16'h0345; cpu_do = 8'h96; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
        tick(); tick();
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        tick(); tick();
        ref_mem[12'h345] = 8'h96;
        checks++; if (we_cnt - w0 != 1) begin failures++; $display("FAIL both_we got %0d want 1", we_cnt - w0); end
        checks++; if (last_we_d !== 8'h96) begin failures++; $display("FAIL both_data got %h want 96", last_we_d); end
        checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL both_no_read got %h want ff", cpu_di); end
        cpu_read(16'h0345, d);
        checks++; if (d !== 8'h96) begin failures++; $display("FAIL both_readback got %h want 96", d); end
    endtask

    task automatic test_short_strobe();
        logic [7:0] d;
        cpu_read(16'hFFF0, d);
        cpu_a = 16'h0010; cpu_rd_n = 1'b0;
        tick();
        cpu_rd_n = 1'b1;
        tick(); tick();
        checks++; if (cpu_di !== 8'h5A) begin failures++; $display("FAIL short_strobe got %h want 5a", cpu_di); end
        tick();
    endtask

    task automatic test_random_cpu();
        logic [15:0] addrs [8];
        logic [15:0] a;
        logic [7:0] d, exp_d;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = {4'h0, 12'($urandom)};
            cpu_write(addrs[i], 8'($urandom));
        end
        for (int n = 0; n < 30; n++) begin
            a = addrs[$urandom_range(0, 7)];
            if ($urandom_range(0, 4) == 0) a[15:12] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                cpu_write(a, 8'($urandom));
            end else begin
                cpu_read(a, d);
                exp_d = hit(a) ? ref_mem[a[11:0]] : 8'hFF;
                checks++; if (d !== exp_d) begin failures++; $display("FAIL rand_read a=%h got %h want %h", a, d, exp_d); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d, q;
        int a0, lat;
        logic wok;
        cpu_read(16'h0010, d);
        cpu_a = 16'h0ABC; cpu_do = 8'h33; cpu_wr_n = 1'b0;
        tick();
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL rstw_in_write got %b want 1", ram_we); end
        rst = 1'b1; cpu_wr_n = 1'b1; a0 = ack_cnt;
        tick();
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rstw_we got %b want 0", ram_we); end
        checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL rstw_cpu_di got %h want ff", cpu_di); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (ack_cnt != a0) begin failures++; $display("FAIL rstw_no_ack got %0d want %0d", ack_cnt, a0); end
        host_access(1'b1, 12'h777, 8'h5C, q, lat, wok);
        checks++; if (lat != 1) begin failures++; $display("FAIL rstw_idle got %0d want 1", lat); end
        checks++; if (wok !== 1'b1) begin failures++; $display("FAIL rstw_ack_width got long want 1 cycle"); end
    endtask

    initial begin
        rst = 1'b1; cpu_a = '0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_do = '0;
        host_req = 1'b0; host_we = 1'b0; host_a = '0; host_d = '0;
        @(negedge clk);
        test_reset();
        test_cpu_write_read();
        test_read_miss();
        test_host_write_read();
        test_host_then_cpu();
        test_back_to_back();
        test_both_strobes();
        test_short_strobe();
        test_random_cpu();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
